vga_fb_scanout: RTL and testbench

//  Pixel stage directly downstream of the 640x480 VGA timing generator. Takes
//  its x/y/active/hs/vs, fetches a downscaled framebuffer pixel (4-bit palette

---
 rtl/vga_fb_pkg.sv | 28 ++
 rtl/fb_ram.sv | 44 ++++
 rtl/vga_fb_scanout.sv | 190 +++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : vga_fb_pkg                                                  |
// | Description: Shared constants and types for the VGA framebuffer scanout: |
// |              default framebuffer geometry, pixel pipeline latency, the   |
// |              12-bit RGB type and the 16-entry CGA palette table.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package vga_fb_pkg;

  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;

  // Cycles from timing-generator inputs to RGB/sync outputs.
  localparam int PIX_LAT = 3;

  typedef logic [11:0] rgb12_t;

  // Standard 16-colour CGA palette, 4 bits per channel (R,G,B).
  localparam rgb12_t CGA_PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fb_ram                                                      |
// | Description: Single-port synchronous framebuffer RAM with one-cycle      |
// |              registered read. Contents are not reset.                    |
// | Ports      : i_clk    clock                                              |
// |              i_we     write enable (writes i_wdata at i_addr)            |
// |              i_re     read enable (o_rdata updates next cycle)           |
// |              i_addr   shared read/write address                          |
// |              i_wdata  write data                                         |
// |              o_rdata  registered read data                               |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module fb_ram
  import vga_fb_pkg::*;
#(
  parameter int DEPTH  = FB_W_DEF * FB_H_DEF,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : vga_fb_scanout                                              |
// | Description: Pixel stage behind a 640x480 VGA timing generator. Fetches  |
// |              an upscaled framebuffer palette index from a single-port    |
// |              RAM, maps it to 12-bit RGB and emits RGB with syncs aligned |
// |              (3-cycle latency). A host write port uses the RAM only on   |
// |              cycles where the display is not reading.                    |
// | Ports      : i_clk/i_rst            pixel clock, async active-high reset |
// |              i_x/i_y/i_active       timing generator position/active     |
// |              i_hs/i_vs              syncs (active low)                   |
// |              i_wr_valid/addr/data   host write request                   |
// |              o_wr_ready             host write accepted when valid&ready |
// |              o_wr_err               pulse: accepted write out of range   |
// |              o_r/o_g/o_b            pixel colour                         |
// |              o_hs/o_vs              delayed syncs (active low)           |
// | Config     : VGA_FB_PALETTE_EN - writable palette registers with extra   |
// |              ports i_pal_we, i_pal_idx, i_pal_rgb; otherwise fixed CGA.  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module vga_fb_scanout
  import vga_fb_pkg::*;
#(
  parameter int FB_W        = FB_W_DEF,
  parameter int FB_H        = FB_H_DEF,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_BITS    = 4,
  parameter int ADDR_W      = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [9:0]          i_x,
  input  logic [8:0]          i_y,
  input  logic                i_active,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_wr_valid,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [PIX_BITS-1:0] i_wr_data,
`ifdef VGA_FB_PALETTE_EN
  input  logic                i_pal_we,
  input  logic [3:0]          i_pal_idx,
  input  rgb12_t              i_pal_rgb,
`endif
  output logic                o_wr_ready,
  output logic                o_wr_err,
  output logic [3:0]          o_r,
  output logic [3:0]          o_g,
  output logic [3:0]          o_b,
  output logic                o_hs,
  output logic                o_vs
);

  localparam int              FB_PIXELS   = FB_W * FB_H;
  localparam logic [ADDR_W:0] FB_PIXELS_W = FB_PIXELS[ADDR_W:0];

  // Reset asserts asynchronously but releases on a clock edge, so no flop
  // sees a reset deassertion close to its sampling edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b0};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int = rst_sync_q[1];

  logic                act1_q,     act1_d;
  logic [ADDR_W-1:0]   addr1_q,    addr1_d;
  logic                act2_q,     act2_d;
  logic [2:0]          hs_q,       hs_d;
  logic [2:0]          vs_q,       vs_d;
  rgb12_t              rgb_q,      rgb_d;
  logic                wr_ready_q, wr_ready_d;
  logic                wr_err_q,   wr_err_d;

  logic                wr_acc;
  logic                wr_in_range;
  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [PIX_BITS-1:0] ram_rdata;
  logic [3:0]          pal_idx;
  rgb12_t              pal_rgb;

  always_comb begin
    // S1: framebuffer address of the downscaled pixel.
    act1_d  = i_active;
    addr1_d = ADDR_W'(i_y >> SCALE_SHIFT) * ADDR_W'(FB_W)
            + ADDR_W'(i_x >> SCALE_SHIFT);
    // S2: RAM read in flight.
    act2_d  = act1_q;
    // S3: palette lookup; blanking forces black.
    rgb_d   = act2_q ? pal_rgb : 12'h000;
    hs_d    = {hs_q[1:0], i_hs};
    vs_d    = {vs_q[1:0], i_vs};

    // The port belongs to the host exactly when S1 holds no active pixel.
    // Ready is registered from i_active so it always equals ~act1 once out
    // of reset, with no combinational path to the output.
    wr_ready_d  = ~i_active;
    wr_acc      = i_wr_valid & wr_ready_q;
    wr_in_range = {1'b0, i_wr_addr} < FB_PIXELS_W;
    wr_err_d    = wr_acc & ~wr_in_range;

    ram_we   = wr_acc & wr_in_range;
    ram_re   = act1_q;
    ram_addr = act1_q ? addr1_q : i_wr_addr;
  end

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      act1_q     <= 1'b0;
      addr1_q    <= '0;
      act2_q     <= 1'b0;
      hs_q       <= 3'b111;
      vs_q       <= 3'b111;
      rgb_q      <= 12'h000;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      act1_q     <= act1_d;
      addr1_q    <= addr1_d;
      act2_q     <= act2_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      wr_ready_q <= wr_ready_d;
      wr_err_q   <= wr_err_d;
    end
  end

  fb_ram #(
    .DEPTH  (FB_PIXELS),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_BITS)
  ) u_fb_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (ram_addr),
    .i_wdata (i_wr_data),
    .o_rdata (ram_rdata)
  );

  assign pal_idx = ram_rdata[3:0];

`ifdef VGA_FB_PALETTE_EN
  rgb12_t pal_q [16];
  rgb12_t pal_d [16];

  always_comb begin
    pal_d = pal_q;
    if (i_pal_we) begin
      pal_d[i_pal_idx] = i_pal_rgb;
    end
  end

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      pal_q <= CGA_PALETTE;
    end else begin
      pal_q <= pal_d;
    end
  end

  // Lookup reads the registered table: a write is visible one cycle later.
  assign pal_rgb = pal_q[pal_idx];
`else
  assign pal_rgb = CGA_PALETTE[pal_idx];
`endif

  assign o_r        = rgb_q[11:8];
  assign o_g        = rgb_q[7:4];
  assign o_b        = rgb_q[3:0];
  assign o_hs       = hs_q[2];
  assign o_vs       = vs_q[2];
  assign o_wr_ready = wr_ready_q;
  assign o_wr_err   = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_vga_fb_scanout                                           |
// | Description: Self-checking bench for vga_fb_scanout. A driver issues     |
// |              directed timing/host vectors and queues the expected pixel  |
// |              and host-port responses; a monitor pops and compares them   |
// |              on the falling edge of the cycle they are due.              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vga_fb_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x_in = '0;
  logic [8:0]  y_in = '0;
  logic        act_in = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        wv_in = 1'b0;
  logic [14:0] wa_in = '0;
  logic [3:0]  wd_in = '0;
`ifdef VGA_FB_PALETTE_EN
  logic        pal_we_in = 1'b0;
  logic [3:0]  pal_idx_in = '0;
  logic [11:0] pal_rgb_in = '0;
  bit          pal_req = 1'b0;
  logic [3:0]  pal_req_idx = '0;
  logic [11:0] pal_req_rgb = '0;
`endif
  logic        wr_ready, wr_err, hs_out, vs_out;
  logic [3:0]  r_out, g_out, b_out;

  vga_fb_scanout u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_x        (x_in),
    .i_y        (y_in),
    .i_active   (act_in),
    .i_hs       (hs_in),
    .i_vs       (vs_in),
    .i_wr_valid (wv_in),
    .i_wr_addr  (wa_in),
    .i_wr_data  (wd_in),
`ifdef VGA_FB_PALETTE_EN
    .i_pal_we   (pal_we_in),
    .i_pal_idx  (pal_idx_in),
    .i_pal_rgb  (pal_rgb_in),
`endif
    .o_wr_ready (wr_ready),
    .o_wr_err   (wr_err),
    .o_r        (r_out),
    .o_g        (g_out),
    .o_b        (b_out),
    .o_hs       (hs_out),
    .o_vs       (vs_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        act;
    logic [3:0]  idx;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          tag;
  } pix_t;

  typedef struct {
    int   due;
    logic rdy;
    logic err;
    int   tag;
  } ctl_t;

  pix_t pix_q[$];
  ctl_t ctl_q[$];

  int checks = 0;
  int passed = 0;
  int tag = 0;

  logic [3:0]  mem_m [0:19199];
  logic [11:0] pal_m [16];
  bit          model_ready = 1'b0;
  bit          ctl_en = 1'b0;

  // ---------------- monitor ----------------
  pix_t mp;
  ctl_t mc;
  always @(negedge clk) begin
    while (pix_q.size() != 0 && pix_q[0].due <= cyc) begin
      mp = pix_q.pop_front();
      checks++;
      if (mp.due == cyc && {r_out, g_out, b_out} === mp.rgb &&
          hs_out === mp.hs && vs_out === mp.vs) begin
        passed++;
      end else begin
        $display("FAIL pix t%0d cyc%0d due%0d: got rgb=%03h hs=%b vs=%b, want rgb=%03h hs=%b vs=%b",
                 mp.tag, cyc, mp.due, {r_out, g_out, b_out}, hs_out, vs_out,
                 mp.rgb, mp.hs, mp.vs);
      end
    end
    while (ctl_q.size() != 0 && ctl_q[0].due <= cyc) begin
      mc = ctl_q.pop_front();
      checks++;
      if (mc.due == cyc && wr_ready === mc.rdy && wr_err === mc.err) begin
        passed++;
      end else begin
        $display("FAIL host t%0d cyc%0d due%0d: got ready=%b err=%b, want ready=%b err=%b",
                 mc.tag, cyc, mc.due, wr_ready, wr_err, mc.rdy, mc.err);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive_cycle(input logic act, input int x, input int y,
                             input logic hs, input logic vs, input logic wv,
                             input int wa, input logic [3:0] wd, output bit acc);
    pix_t p;
    ctl_t c;
    bit   err;
    @(posedge clk);
    #1;
    act_in = act; x_in = 10'(x); y_in = 9'(y); hs_in = hs; vs_in = vs;
    wv_in = wv; wa_in = 15'(wa); wd_in = wd;
`ifdef VGA_FB_PALETTE_EN
    pal_we_in = pal_req; pal_idx_in = pal_req_idx; pal_rgb_in = pal_req_rgb;
    if (pal_req) begin
      pal_m[pal_req_idx] = pal_req_rgb;
      // Lookups at least two edges away see the new colour.
      for (int k = 0; k < pix_q.size(); k++) begin
        p = pix_q[k];
        if (p.due >= cyc + 2 && p.act && p.idx == pal_req_idx) begin
          p.rgb = pal_req_rgb;
          pix_q[k] = p;
        end
      end
      pal_req = 1'b0;
    end
`endif
    acc = wv && model_ready;
    err = acc && (wa >= 19200);
    if (acc && !err) mem_m[wa] = wd;
    p.due = cyc + 3; p.act = act; p.hs = hs; p.vs = vs; p.tag = tag;
    p.idx = act ? mem_m[(y >> 2) * 160 + (x >> 2)] : 4'd0;
    p.rgb = act ? pal_m[p.idx] : 12'h000;
    pix_q.push_back(p);
    if (ctl_en) begin
      c.due = cyc + 1; c.rdy = !act; c.err = err; c.tag = tag;
      ctl_q.push_back(c);
    end
    model_ready = !act;
  endtask

  task automatic idle();
    bit acc;
    drive_cycle(1'b0, 700, 500, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
  endtask

  task automatic host_write(input int wa, input logic [3:0] wd);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 32) begin
      drive_cycle(1'b0, 700, 500, 1'b1, 1'b1, 1'b1, wa, wd, acc);
      n++;
    end
    checks++;
    if (acc) passed++;
    else $display("FAIL write_timeout addr %0d: got no acceptance, want one within 32 cycles", wa);
    idle();
  endtask

  task automatic push_reset_items();
    pix_t p;
    ctl_t c;
    p.due = cyc; p.act = 1'b0; p.idx = 4'd0; p.rgb = 12'h000;
    p.hs = 1'b1; p.vs = 1'b1; p.tag = tag;
    pix_q.push_back(p);
    c.due = cyc; c.rdy = 1'b0; c.err = 1'b0; c.tag = tag;
    ctl_q.push_back(c);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    bit          acc;
    int          n;
    logic [11:0] hs_pat;
    logic [11:0] vs_pat;

    pal_m = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
              12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 19200; i++) mem_m[i] = 4'd0;

    // Reset state.
    tag = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      push_reset_items();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) idle();
    ctl_en = 1'b1;

    // 1: blanking only, syncs delayed three cycles, RGB black.
    tag = 1;
    hs_pat = 12'b1100_1011_0110;
    vs_pat = 12'b1011_0011_1100;
    for (int i = 0; i < 12; i++)
      drive_cycle(1'b0, 640 + i, 480, hs_pat[i], vs_pat[i], 1'b0, 0, 4'd0, acc);

    // Framebuffer preload during blanking.
    tag = 2;
    host_write(0, 4'd15);
    host_write(1, 4'd0);
    host_write(2, 4'd15);
    host_write(3, 4'd15);
    host_write(320, 4'd3);
    host_write(321, 4'd5);
    host_write(322, 4'd10);
    host_write(323, 4'd12);
    host_write(500, 4'd0);
    host_write(712, 4'd4);
    host_write(713, 4'd4);
    host_write(714, 4'd4);
    host_write(715, 4'd9);

    // 2: 4x4 block of pixel 0 is white, x=4 maps to pixel 1 (black).
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 5; x++)
        drive_cycle(1'b1, x, y, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
      for (int j = 0; j < 3; j++)
        drive_cycle(1'b0, 640 + j, y, 1'b0, 1'b1, 1'b0, 0, 4'd0, acc);
    end

    // 3: host write held through an active line; taken once S1 goes idle.
    tag = 3;
    for (int x = 0; x < 16; x++)
      drive_cycle(1'b1, x, 8, 1'b1, 1'b1, x >= 1, 500, 4'd7, acc);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 8) begin
      drive_cycle(1'b0, 640 + n, 8, 1'b1, 1'b1, 1'b1, 500, 4'd7, acc);
      n++;
    end
    idle();
    for (int x = 80; x < 84; x++)
      drive_cycle(1'b1, x, 12, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
    repeat (2) idle();

    // 4: out-of-range write flags an error and leaves pixel 0 intact.
    tag = 4;
    host_write(19200, 4'd3);
    for (int x = 0; x < 4; x++)
      drive_cycle(1'b1, x, 0, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
    repeat (2) idle();

    // 5: reset in the middle of a line at x=300.
    tag = 5;
    for (int x = 288; x < 300; x++)
      drive_cycle(1'b1, x, 16, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
    @(posedge clk);
    #1;
    while (pix_q.size() != 0 && pix_q[$].due >= cyc) void'(pix_q.pop_back());
    while (ctl_q.size() != 0 && ctl_q[$].due >= cyc) void'(ctl_q.pop_back());
    rst = 1'b1;
    act_in = 1'b1; x_in = 10'd300;
    push_reset_items();
    repeat (2) begin
      @(posedge clk);
      #1;
      x_in = x_in + 10'd1;
      push_reset_items();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ctl_en = 1'b0;
    model_ready = 1'b0;
    act_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    repeat (4) idle();
    ctl_en = 1'b1;
    drive_cycle(1'b1, 300, 16, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
    repeat (4) idle();

    // 6: index 15 on screen; palette entry rewritten mid-line when enabled.
    tag = 6;
    for (int x = 8; x < 16; x++) begin
`ifdef VGA_FB_PALETTE_EN
      if (x == 10) begin
        pal_req = 1'b1;
        pal_req_idx = 4'd15;
        pal_req_rgb = 12'hF00;
      end
`endif
      drive_cycle(1'b1, x, 0, 1'b1, 1'b1, 1'b0, 0, 4'd0, acc);
    end
    repeat (4) idle();

    n = 0;
    while ((pix_q.size() != 0 || ctl_q.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (pix_q.size() == 0 && ctl_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pix and %0d host items pending, want 0",
                  pix_q.size(), ctl_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish earlier");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
